exec_stage: RTL and testbench

//  - MIPS 5-stage pipeline EX stage: operand forwarding, ALU, branch resolution, and the EX/MEM pipeline register.
//  - Fed by the ID/EX register; its registered outputs feed the MEM stage.
//  - Drives branch redirect to fetch and EX dest/reg-write to the hazard unit.

---
 rtl/exec_pkg.sv | 65 ++++++
 rtl/exec_stage_fwd_unit.sv | 29 ++
 rtl/exec_stage.sv | 164 ++++++++++++++++
 tb/tb_exec_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// ============================================================================
// Module   : exec_pkg
// Purpose  : Shared types and constants for the EX stage. The types cover the
//            ALU ops, funct codes, forwarding selects and branch kinds.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package exec_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_LUI  = 4'd8,
    ALU_FUNC = 4'd15
  } alu_op_e;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } branch_e;

  // The EX/MEM result is younger than the WB value, so it takes priority.
  // Register 0 is hard-wired to zero and is never a forwarding target.
  function automatic fwd_sel_e fwd_pick(input logic       mem_we,
                                        input logic [4:0] mem_dest,
                                        input logic       wb_we,
                                        input logic [4:0] wb_dest,
                                        input logic [4:0] addr);
    if (mem_we && (mem_dest != 5'd0) && (mem_dest == addr)) return FWD_MEM;
    if (wb_we && (wb_dest != 5'd0) && (wb_dest == addr))    return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_stage_fwd_unit.sv
// ============================================================================
// Module   : fwd_unit
// Purpose  : Combinational operand-forwarding selects for the rs and rt
//            operands of the EX stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_unit
  import exec_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic [4:0] rt_addr_i,
  input  logic       exmem_reg_write_i,
  input  logic [4:0] exmem_dest_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_addr_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = fwd_pick(exmem_reg_write_i, exmem_dest_i,
                            wb_reg_write_i, wb_addr_i, rs_addr_i);
  assign fwd_b_o = fwd_pick(exmem_reg_write_i, exmem_dest_i,
                            wb_reg_write_i, wb_addr_i, rt_addr_i);

endmodule

`default_nettype wire

// File: rtl/exec_stage.sv
// ============================================================================
// Module   : exec_stage
// Purpose  : MIPS EX stage. It contains operand forwarding, the ALU, branch
//            resolution and the EX/MEM pipeline register.
//            Build macro EXEC_FWD_EN enables forwarding. When the macro is
//            undefined, operands come straight from ID/EX.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_stage
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc4,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [3:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic [1:0]  branch,
  input  logic [31:0] imm_ext,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [5:0]  func,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [4:0]  dest_ex,
  output logic        branch_taken,
  output logic [31:0] pc_branch,
  output logic        mem_to_reg_q,
  output logic        reg_write_q,
  output logic        mem_write_q,
  output logic        mem_read_q,
  output logic [31:0] alu_result_q,
  output logic [31:0] store_data_q,
  output logic [4:0]  dest_q
);

  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic [31:0] w_op_a;
  logic [31:0] w_rt_fwd;
  logic [31:0] w_op_b;
  logic [4:0]  w_shamt;
  logic [31:0] alu_result_d;

`ifdef EXEC_FWD_EN
  fwd_unit u_fwd (
    .rs_addr_i         (rs_addr),
    .rt_addr_i         (rt_addr),
    .exmem_reg_write_i (reg_write_q),
    .exmem_dest_i      (dest_q),
    .wb_reg_write_i    (wb_reg_write),
    .wb_addr_i         (wb_addr),
    .fwd_a_o           (w_fwd_a),
    .fwd_b_o           (w_fwd_b)
  );
`else
  // Without forwarding, software inserts NOPs, so the hazard sources are
  // deliberately ignored.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{rs_addr, wb_reg_write, wb_addr};
  assign w_fwd_a      = FWD_NONE;
  assign w_fwd_b      = FWD_NONE;
`endif

  always_comb begin
    w_op_a = rs_data;
    case (w_fwd_a)
      FWD_MEM: w_op_a = alu_result_q;
      FWD_WB:  w_op_a = wb_data;
      default: w_op_a = rs_data;
    endcase
  end

  always_comb begin
    w_rt_fwd = rt_data;
    case (w_fwd_b)
      FWD_MEM: w_rt_fwd = alu_result_q;
      FWD_WB:  w_rt_fwd = wb_data;
      default: w_rt_fwd = rt_data;
    endcase
  end

  assign w_op_b  = alu_src ? imm_ext : w_rt_fwd;
  assign w_shamt = imm_ext[10:6];

  always_comb begin
    alu_result_d = 32'd0;
    case (alu_op)
      ALU_ADD:  alu_result_d = w_op_a + w_op_b;
      ALU_SUB:  alu_result_d = w_op_a - w_op_b;
      ALU_AND:  alu_result_d = w_op_a & w_op_b;
      ALU_OR:   alu_result_d = w_op_a | w_op_b;
      ALU_XOR:  alu_result_d = w_op_a ^ w_op_b;
      ALU_NOR:  alu_result_d = ~(w_op_a | w_op_b);
      ALU_SLT:  alu_result_d = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLTU: alu_result_d = {31'd0, (w_op_a < w_op_b)};
      ALU_LUI:  alu_result_d = {w_op_b[15:0], 16'h0000};
      ALU_FUNC: begin
        // R-type shifts always act on rt, independent of alu_src.
        case (func)
          FN_ADD, FN_ADDU: alu_result_d = w_op_a + w_op_b;
          FN_SUB, FN_SUBU: alu_result_d = w_op_a - w_op_b;
          FN_AND:  alu_result_d = w_op_a & w_op_b;
          FN_OR:   alu_result_d = w_op_a | w_op_b;
          FN_XOR:  alu_result_d = w_op_a ^ w_op_b;
          FN_NOR:  alu_result_d = ~(w_op_a | w_op_b);
          FN_SLT:  alu_result_d = {31'd0, ($signed(w_op_a) < $signed(w_op_b))};
          FN_SLTU: alu_result_d = {31'd0, (w_op_a < w_op_b)};
          FN_SLL:  alu_result_d = w_rt_fwd << w_shamt;
          FN_SRL:  alu_result_d = w_rt_fwd >> w_shamt;
          FN_SRA:  alu_result_d = $signed(w_rt_fwd) >>> w_shamt;
          default: alu_result_d = 32'd0;
        endcase
      end
      default:  alu_result_d = 32'd0;
    endcase
  end

  // Branch compare uses forwarded rt, not the possibly-immediate B operand.
  always_comb begin
    branch_taken = 1'b0;
    case (branch)
      BR_BEQ:  branch_taken = (w_op_a == w_rt_fwd);
      BR_BNE:  branch_taken = (w_op_a != w_rt_fwd);
      default: branch_taken = 1'b0;
    endcase
  end

  assign pc_branch = pc4 + {imm_ext[29:0], 2'b00};
  assign dest_ex   = reg_dst ? rd_addr : rt_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      alu_result_q <= 32'd0;
      store_data_q <= 32'd0;
      dest_q       <= 5'd0;
    end else begin
      mem_to_reg_q <= mem_to_reg;
      reg_write_q  <= reg_write;
      mem_write_q  <= mem_write;
      mem_read_q   <= mem_read;
      alu_result_q <= alu_result_d;
      store_data_q <= w_rt_fwd;
      dest_q       <= dest_ex;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_stage.sv
// ============================================================================
// Module   : tb_exec_stage
// Purpose  : Directed and randomized checks of exec_stage against a
//            behavioural reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_exec_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc4;
  logic        mem_to_reg, reg_write, mem_write, mem_read;
  logic [3:0]  alu_op;
  logic        alu_src, reg_dst;
  logic [1:0]  branch;
  logic [31:0] imm_ext;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic [5:0]  func;
  logic        wb_reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  dest_ex;
  logic        branch_taken;
  logic [31:0] pc_branch;
  logic        mem_to_reg_q, reg_write_q, mem_write_q, mem_read_q;
  logic [31:0] alu_result_q, store_data_q;
  logic [4:0]  dest_q;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .reset(reset), .pc4(pc4),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_write(mem_write), .mem_read(mem_read),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch),
    .imm_ext(imm_ext), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .func(func),
    .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .dest_ex(dest_ex), .branch_taken(branch_taken), .pc_branch(pc_branch),
    .mem_to_reg_q(mem_to_reg_q), .reg_write_q(reg_write_q),
    .mem_write_q(mem_write_q), .mem_read_q(mem_read_q),
    .alu_result_q(alu_result_q), .store_data_q(store_data_q), .dest_q(dest_q)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Reference model: the EX/MEM contents it predicts for the previous instruction.
  logic        m_m2r, m_rw, m_mw, m_mr;
  logic [31:0] m_res, m_st;
  logic [4:0]  m_dest;

  function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] idex);
`ifdef EXEC_FWD_EN
    if (m_rw && m_dest != 0 && m_dest == addr) return m_res;
    if (wb_reg_write && wb_addr != 0 && wb_addr == addr) return wb_data;
`endif
    return idex;
  endfunction

  function automatic logic [31:0] alu_model(input int op, input int fn,
      input logic [31:0] a, input logic [31:0] b, input logic [31:0] t, input int sh);
    int eff;
    eff = op;
    if (op == 15) begin
      case (fn)
        'h20, 'h21: eff = 0;
        'h22, 'h23: eff = 1;
        'h24: eff = 2;
        'h25: eff = 3;
        'h26: eff = 4;
        'h27: eff = 5;
        'h2A: eff = 6;
        'h2B: eff = 7;
        'h00: return t << sh;
        'h02: return t >> sh;
        'h03: return $signed(t) >>> sh;
        default: return 0;
      endcase
    end
    case (eff)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ~(a | b);
      6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7: return (a < b) ? 32'd1 : 32'd0;
      8: return (b & 32'h0000FFFF) * 32'd65536;
      default: return 0;
    endcase
  endfunction

  task automatic cycle(input bit chk_comb);
    logic [31:0] a, t, b, res;
    logic [4:0]  d;
    logic        tk;
    a   = fwd(rs_addr, rs_data);
    t   = fwd(rt_addr, rt_data);
    b   = alu_src ? imm_ext : t;
    res = alu_model(int'(alu_op), int'(func), a, b, t, int'(imm_ext[10:6]));
    d   = reg_dst ? rd_addr : rt_addr;
    tk  = (branch == 2'b01 && a == t) || (branch == 2'b10 && a != t);
    #1;
    if (chk_comb) begin
      check("dest_ex", dest_ex, d);
      check("branch_taken", branch_taken, tk);
      check("pc_branch", pc_branch, pc4 + imm_ext * 32'd4);
    end
    @(posedge clk);
    if (!reset) begin
      {m_m2r, m_rw, m_mw, m_mr} = 4'b0;
      m_res = 0; m_st = 0; m_dest = 0;
    end else begin
      m_m2r = mem_to_reg; m_rw = reg_write; m_mw = mem_write; m_mr = mem_read;
      m_res = res; m_st = t; m_dest = d;
    end
    #1;
    check("mem_to_reg_q", mem_to_reg_q, m_m2r);
    check("reg_write_q", reg_write_q, m_rw);
    check("mem_write_q", mem_write_q, m_mw);
    check("mem_read_q", mem_read_q, m_mr);
    check("alu_result_q", alu_result_q, m_res);
    check("store_data_q", store_data_q, m_st);
    check("dest_q", dest_q, m_dest);
  endtask

  task automatic clear();
    pc4 = 0; mem_to_reg = 0; reg_write = 0; mem_write = 0; mem_read = 0;
    alu_op = 0; alu_src = 0; reg_dst = 0; branch = 0; imm_ext = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0; func = 0;
    wb_reg_write = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic rand_inputs();
    logic [5:0] fns [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                             6'h26, 6'h27, 6'h2A, 6'h2B, 6'h03};
    pc4 = $urandom; mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
    mem_write = 1'($urandom); mem_read = 1'($urandom);
    alu_op = 4'($urandom_range(0, 15)); alu_src = 1'($urandom);
    reg_dst = 1'($urandom); branch = 2'($urandom);
    imm_ext = {{16{1'($urandom)}}, 16'($urandom)};
    rs_addr = 5'($urandom_range(0, 3)); rt_addr = 5'($urandom_range(0, 3));
    rd_addr = 5'($urandom_range(0, 3));
    rs_data = ($urandom_range(0, 3) == 0) ? rt_data : $urandom;
    rt_data = $urandom;
    case ($urandom_range(0, 7))
      0: func = 6'($urandom);
      1: func = 6'h00;
      2: func = 6'h02;
      default: func = fns[$urandom_range(0, 10)];
    endcase
    wb_reg_write = 1'($urandom); wb_addr = 5'($urandom_range(0, 3));
    wb_data = $urandom;
  endtask

  initial begin
    reset = 1'b0;
    rt_data = 32'h1;
    rand_inputs();
    reg_write = 1; mem_read = 1; rs_data = 32'hDEADBEEF;
    repeat (2) cycle(1'b0);
    check("rst_alu_zero", alu_result_q, 32'd0);
    check("rst_rw_zero", reg_write_q, 1'b0);
    reset = 1'b1;

    // ADD via funct, no hazards
    clear();
    alu_op = 4'd15; func = 6'h20; rs_addr = 1; rs_data = 5; rt_addr = 2;
    rt_data = 7; reg_dst = 1; rd_addr = 3; reg_write = 1;
    cycle(1'b1);
    check("add_res", alu_result_q, 32'd12);
    check("add_dest", dest_q, 32'd3);

    // EX/MEM forward beats a pending WB on the same register
    clear();
    rs_addr = 3; rs_data = 0; rt_addr = 4; rt_data = 1; reg_write = 1;
    wb_reg_write = 1; wb_addr = 3; wb_data = 99;
    cycle(1'b1);
`ifdef EXEC_FWD_EN
    check("fwd_mem", alu_result_q, 32'd13);
`else
    check("fwd_off", alu_result_q, 32'd1);
`endif

    // WB-only forward
    clear();
    rs_addr = 9; rs_data = 2; rt_addr = 10; rt_data = 3;
    wb_reg_write = 1; wb_addr = 9; wb_data = 40;
    cycle(1'b1);

    // Register 0 never forwarded
    clear();
    rs_addr = 11; rs_data = 77; reg_write = 1; reg_dst = 1; rd_addr = 0;
    cycle(1'b1);
    clear();
    rs_addr = 0; rs_data = 5; rt_addr = 0; rt_data = 6;
    wb_reg_write = 1; wb_addr = 0; wb_data = 123;
    cycle(1'b1);
    check("reg0_nofwd", alu_result_q, 32'd11);

    // BEQ taken, then BNE not taken, with equal operands
    clear();
    branch = 2'b01; rs_addr = 12; rt_addr = 13; rs_data = 42; rt_data = 42;
    pc4 = 32'h100; imm_ext = 32'd4;
    #1;
    check("beq_taken", branch_taken, 1'b1);
    check("beq_target", pc_branch, 32'h110);
    cycle(1'b1);
    branch = 2'b10;
    #1;
    check("bne_not_taken", branch_taken, 1'b0);
    cycle(1'b1);

    // SRA, LUI, SLT, SLTU
    clear();
    alu_op = 4'd15; func = 6'h03; rt_addr = 14; rt_data = 32'h80000000;
    imm_ext = 32'd4 << 6;
    cycle(1'b1);
    check("sra", alu_result_q, 32'hF8000000);
    clear();
    alu_op = 4'd8; alu_src = 1; imm_ext = 32'h1234;
    cycle(1'b1);
    check("lui", alu_result_q, 32'h12340000);
    clear();
    alu_op = 4'd6; rs_addr = 15; rs_data = 32'hFFFFFFFF; rt_addr = 16; rt_data = 1;
    cycle(1'b1);
    check("slt", alu_result_q, 32'd1);
    alu_op = 4'd7;
    cycle(1'b1);
    check("sltu", alu_result_q, 32'd0);

    // Randomized traffic with dense register-address collisions
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 31) != 0);
      cycle(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
